// File: rtl/readout_tx_multi_tone_gen.sv
// Multi-channel NCO tone generator for readout pulses: shared sine LUT, per-channel
// phase accumulators, amplitude scaling and a summed output, with a 4-cycle start-to-sample latency.
module readout_tx_multi_tone_gen #(
   parameter int NUM_CH             = 4,
   parameter int NCO_N              = 22,
   parameter int PHASE_WIDTH        = 10,
   parameter int SIN_LUT_DATA_WIDTH = 16,
   parameter int AMP_WIDTH          = 9,
   parameter int DUR_WIDTH          = 16,
   localparam int CSW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int OW  = SIN_LUT_DATA_WIDTH + $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_wr_en,
   input  logic [CSW-1:0]                cfg_ch_sel,
   input  logic [NCO_N-1:0]              cfg_ftw,
   input  logic [PHASE_WIDTH-1:0]        cfg_phase_off,
   input  logic [AMP_WIDTH-1:0]          cfg_amp,
   input  logic                          cfg_ch_en,
   input  logic                          sin_lut_wr_en,
   input  logic [PHASE_WIDTH-1:0]        sin_lut_wr_addr,
   input  logic [SIN_LUT_DATA_WIDTH-1:0] sin_lut_wr_data,
   input  logic                          pulse_start,
   input  logic [DUR_WIDTH-1:0]          pulse_dur,
   output logic                          busy,
   output logic                          done,
   output logic                          valid_wave_out,
   output logic [OW-1:0]                 wave_out
);

   localparam int DW        = SIN_LUT_DATA_WIDTH;
   localparam int PW        = DW + AMP_WIDTH + 1;
   localparam int LUT_DEPTH = 1 << PHASE_WIDTH;
   localparam logic [AMP_WIDTH-1:0] AMP_UNITY = {1'b1, {(AMP_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                   state_q, state_d;
   logic                     issue, load, zero_start;

   logic [NCO_N-1:0]         ftw_q [NUM_CH];
   logic [PHASE_WIDTH-1:0]   off_q [NUM_CH];
   logic [AMP_WIDTH-1:0]     amp_q [NUM_CH];
   logic [NUM_CH-1:0]        en_q;

   logic [NCO_N-1:0]         acc_q [NUM_CH];
   logic [DUR_WIDTH-1:0]     cnt_q;

   logic                     valid_a_q, valid_b_q, valid_c_q, valid_q;
   logic                     last_a_q, last_b_q, last_c_q, done_q;
   logic [PHASE_WIDTH-1:0]   addr_q  [NUM_CH];
   logic [AMP_WIDTH-1:0]     amp_a_q [NUM_CH];
   logic [AMP_WIDTH-1:0]     amp_b_q [NUM_CH];
   logic [NUM_CH-1:0]        en_a_q, en_b_q;
   logic signed [DW-1:0]     lut_mem [LUT_DEPTH];
   logic signed [DW-1:0]     lut_q    [NUM_CH];
   logic signed [DW-1:0]     scaled_q [NUM_CH];
   logic signed [PW-1:0]     prod     [NUM_CH];
   logic signed [DW-1:0]     scaled_d [NUM_CH];
   logic signed [OW-1:0]     sum_d;
   logic [OW-1:0]            wave_q;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (pulse_start && (pulse_dur != '0)) state_d = S_RUN;
         S_RUN:   if (cnt_q == DUR_WIDTH'(1))          state_d = S_DRAIN;
         S_DRAIN: if (done_q)                          state_d = S_IDLE;
         default:                                      state_d = S_IDLE;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      busy       = 1'b0;
      issue      = 1'b0;
      load       = 1'b0;
      zero_start = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            load       = pulse_start && (pulse_dur != '0);
            zero_start = pulse_start && (pulse_dur == '0);
         end
         S_RUN: begin
            busy  = 1'b1;
            issue = 1'b1;
         end
         S_DRAIN: busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ftw_q[c] <= '0;
            off_q[c] <= '0;
            amp_q[c] <= '0;
         end
         en_q <= '0;
      end else if (cfg_wr_en) begin
         ftw_q[cfg_ch_sel] <= cfg_ftw;
         off_q[cfg_ch_sel] <= cfg_phase_off;
         amp_q[cfg_ch_sel] <= cfg_amp;
         en_q[cfg_ch_sel]  <= cfg_ch_en;
      end
   end

   // Control state and output registers; the last-sample tag travels with each valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
         valid_a_q <= 1'b0;
         valid_b_q <= 1'b0;
         valid_c_q <= 1'b0;
         valid_q   <= 1'b0;
         last_a_q  <= 1'b0;
         last_b_q  <= 1'b0;
         last_c_q  <= 1'b0;
         done_q    <= 1'b0;
         wave_q    <= '0;
      end else begin
         if (load) begin
            cnt_q <= pulse_dur;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
         end else if (issue) begin
            cnt_q <= cnt_q - DUR_WIDTH'(1);
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_q[c] + ftw_q[c];
         end
         valid_a_q <= issue;
         last_a_q  <= issue && (cnt_q == DUR_WIDTH'(1));
         valid_b_q <= valid_a_q;
         last_b_q  <= last_a_q;
         valid_c_q <= valid_b_q;
         last_c_q  <= last_b_q;
         valid_q   <= valid_c_q;
         done_q    <= (valid_c_q && last_c_q) || zero_start;
         wave_q    <= valid_c_q ? sum_d : '0;
      end
   end

   // Datapath registers carry no reset: the valid chain alone decides what reaches the output.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         addr_q[c]   <= acc_q[c][NCO_N-1 -: PHASE_WIDTH] + off_q[c];
         amp_a_q[c]  <= (amp_q[c] > AMP_UNITY) ? AMP_UNITY : amp_q[c];
         amp_b_q[c]  <= amp_a_q[c];
         scaled_q[c] <= en_b_q[c] ? scaled_d[c] : '0;
      end
      en_a_q <= en_q;
      en_b_q <= en_a_q;
   end

   // NOTE: the LUT is memory and is never reset; non-blocking read and write in the same
   // block make a same-address read return the old contents.
   always_ff @(posedge clk) begin
      if (sin_lut_wr_en) lut_mem[sin_lut_wr_addr] <= sin_lut_wr_data;
      for (int c = 0; c < NUM_CH; c++) lut_q[c] <= lut_mem[addr_q[c]];
   end

   always_comb begin
      sum_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         prod[c]     = PW'(lut_q[c]) * PW'($signed({1'b0, amp_b_q[c]}));
         scaled_d[c] = DW'(prod[c] >>> (AMP_WIDTH - 1));
         sum_d       = sum_d + OW'(scaled_q[c]);
      end
   end

   assign done           = done_q;
   assign valid_wave_out = valid_q;
   assign wave_out       = wave_q;

endmodule

// File: tb/tb_readout_tx_multi_tone_gen.sv
// Scoreboard bench for readout_tx_multi_tone_gen: each accepted pulse pushes its expected
// samples (value, last flag, arrival cycle) computed from a reference model of the tone formula.
module tb_readout_tx_multi_tone_gen;

   localparam int NUM_CH = 4;
   localparam int OW     = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_wr_en;
   logic [1:0]    cfg_ch_sel;
   logic [21:0]   cfg_ftw;
   logic [9:0]    cfg_phase_off;
   logic [8:0]    cfg_amp;
   logic          cfg_ch_en;
   logic          sin_lut_wr_en;
   logic [9:0]    sin_lut_wr_addr;
   logic [15:0]   sin_lut_wr_data;
   logic          pulse_start;
   logic [15:0]   pulse_dur;
   logic          busy, done, valid_wave_out;
   logic [OW-1:0] wave_out;

   always #5 clk = ~clk;

   readout_tx_multi_tone_gen #(
      .NUM_CH(4), .NCO_N(22), .PHASE_WIDTH(10), .SIN_LUT_DATA_WIDTH(16),
      .AMP_WIDTH(9), .DUR_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_wr_en(cfg_wr_en), .cfg_ch_sel(cfg_ch_sel), .cfg_ftw(cfg_ftw),
      .cfg_phase_off(cfg_phase_off), .cfg_amp(cfg_amp), .cfg_ch_en(cfg_ch_en),
      .sin_lut_wr_en(sin_lut_wr_en), .sin_lut_wr_addr(sin_lut_wr_addr),
      .sin_lut_wr_data(sin_lut_wr_data),
      .pulse_start(pulse_start), .pulse_dur(pulse_dur),
      .busy(busy), .done(done), .valid_wave_out(valid_wave_out), .wave_out(wave_out)
   );

   typedef struct packed {
      int wave;
      bit last;
      int cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mon_on = 1'b0;
   int   samples_seen = 0;
   int   stray_done = 0;
   int   last_t0 = 0;
   int   lut_m [1024];
   int   m_ftw [NUM_CH];
   int   m_off [NUM_CH];
   int   m_amp [NUM_CH];
   bit   m_en  [NUM_CH];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int model_sample(int k);
      int     s = 0;
      longint acc;
      int     addr;
      int     a;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_en[c]) begin
            acc  = (longint'(k) * longint'(m_ftw[c])) & 64'h3F_FFFF;
            addr = (int'(acc >> 12) + m_off[c]) & 1023;
            a    = (m_amp[c] > 256) ? 256 : m_amp[c];
            s    = s + ((lut_m[addr] * a) >>> 8);
         end
      end
      return s;
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (valid_wave_out === 1'b1) begin
            samples_seen++;
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL extra_sample: got wave=%0d at cycle %0d, required no sample",
                        $signed(wave_out), cyc);
            end else begin
               mon_e = sb_q.pop_front();
               total++;
               if (wave_out !== OW'(mon_e.wave)) begin
                  bad++;
                  $display("FAIL sample_value: got %0d, required %0d", $signed(wave_out), mon_e.wave);
               end
               total++;
               if (done !== mon_e.last) begin
                  bad++;
                  $display("FAIL done_flag: got %b, required %b", done, mon_e.last);
               end
               total++;
               if (cyc !== mon_e.cyc) begin
                  bad++;
                  $display("FAIL sample_timing: got cycle %0d, required %0d", cyc, mon_e.cyc);
               end
            end
         end else begin
            if (done === 1'b1) stray_done++;
            total++;
            if (wave_out !== '0) begin
               bad++;
               $display("FAIL idle_wave_zero: got %0d, required 0", $signed(wave_out));
            end
         end
      end
   end

   task automatic lut_write(int a, int d);
      sin_lut_wr_en   = 1'b1;
      sin_lut_wr_addr = 10'(a);
      sin_lut_wr_data = 16'(d);
      lut_m[a]        = d;
      @(negedge clk);
      sin_lut_wr_en   = 1'b0;
   endtask

   task automatic cfg_write(int c, int ftw, int off, int amp, bit en);
      cfg_wr_en     = 1'b1;
      cfg_ch_sel    = 2'(c);
      cfg_ftw       = 22'(ftw);
      cfg_phase_off = 10'(off);
      cfg_amp       = 9'(amp);
      cfg_ch_en     = en;
      m_ftw[c] = ftw; m_off[c] = off; m_amp[c] = amp; m_en[c] = en;
      @(negedge clk);
      cfg_wr_en     = 1'b0;
   endtask

   task automatic clear_model_cfg();
      for (int c = 0; c < NUM_CH; c++) begin
         m_ftw[c] = 0; m_off[c] = 0; m_amp[c] = 0; m_en[c] = 1'b0;
      end
   endtask

   // Pushes the first n_push samples of a D-sample pulse; n_push=0 for a start that must be ignored.
   task automatic start_pulse(int d, int n_push);
      exp_t e;
      last_t0     = cyc + 1;
      pulse_start = 1'b1;
      pulse_dur   = 16'(d);
      for (int k = 0; k < n_push; k++) begin
         e.wave = model_sample(k);
         e.last = (k == d - 1);
         e.cyc  = last_t0 + 4 + k;
         sb_q.push_back(e);
      end
      @(negedge clk);
      pulse_start = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while ((busy !== 1'b0 || sb_q.size() != 0) && n < 70000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (n >= 70000) begin
         bad++;
         $display("FAIL %s_timeout: %0d samples still pending, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic load_sine();
      for (int i = 0; i < 1024; i++)
         lut_write(i, $rtoi($floor(32767.0 * $sin(2.0 * 3.14159265358979 * i / 1024.0) + 0.5)));
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total += 4;
      if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (done !== 1'b0)           begin bad++; $display("FAIL reset_done: got %b, required 0", done); end
      if (valid_wave_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_wave_out); end
      if (wave_out !== '0)         begin bad++; $display("FAIL reset_wave: got %0d, required 0", $signed(wave_out)); end
      rst = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_tone();
      cfg_write(0, 1 << 12, 0, 256, 1'b1);
      start_pulse(8, 8);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_after_t0: got %b, required 1", busy); end
      wait_idle("single");
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b, required 0", busy); end
   endtask

   task automatic test_multi_tone();
      for (int i = 0; i < 1024; i++) lut_write(i, i);
      cfg_write(0, 1 << 12, 0, 256, 1'b1);
      cfg_write(1, 3 << 12, 100, 256, 1'b1);
      cfg_write(2, 5 << 13, 200, 256, 1'b1);
      cfg_write(3, 123457, 1000, 256, 1'b1);
      start_pulse(6, 6);
      wait_idle("multi_ramp");
      for (int i = 0; i < 1024; i++) lut_write(i, 32767);
      start_pulse(3, 3);
      wait_idle("multi_fullscale");
   endtask

   task automatic test_offset_clip();
      load_sine();
      for (int c = 1; c < NUM_CH; c++) cfg_write(c, 0, 0, 0, 1'b0);
      cfg_write(0, 1 << 21, 1023, 511, 1'b1);
      start_pulse(4, 4);
      wait_idle("clip_511");
      cfg_write(0, 1 << 21, 1023, 256, 1'b1);
      start_pulse(4, 4);
      wait_idle("clip_256");
      cfg_write(0, 1 << 21, 1023, 128, 1'b1);
      start_pulse(4, 4);
      wait_idle("clip_128");
   endtask

   task automatic test_zero_len();
      int sd = stray_done;
      start_pulse(0, 0);
      total += 3;
      if (done !== 1'b1)           begin bad++; $display("FAIL zero_len_done: got %b, required 1", done); end
      if (busy !== 1'b0)           begin bad++; $display("FAIL zero_len_busy: got %b, required 0", busy); end
      if (valid_wave_out !== 1'b0) begin bad++; $display("FAIL zero_len_valid: got %b, required 0", valid_wave_out); end
      repeat (6) @(negedge clk);
      total++;
      if (stray_done !== sd + 1) begin
         bad++;
         $display("FAIL zero_len_done_count: got %0d, required %0d", stray_done - sd, 1);
      end
   endtask

   task automatic test_back_to_back();
      int s0 = samples_seen;
      int n  = 0;
      start_pulse(6, 6);
      @(negedge clk);
      start_pulse(3, 0);
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      start_pulse(3, 0);
      wait_idle("busy_ignore");
      total++;
      if (samples_seen - s0 !== 6) begin
         bad++;
         $display("FAIL busy_ignore_count: got %0d samples, required 6", samples_seen - s0);
      end
   endtask

   task automatic test_long();
      int s0 = samples_seen;
      cfg_write(0, 12345, 7, 300, 1'b1);
      start_pulse(65535, 65535);
      wait_idle("long");
      total++;
      if (samples_seen - s0 !== 65535) begin
         bad++;
         $display("FAIL long_count: got %0d samples, required 65535", samples_seen - s0);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int sd = stray_done;
      int n  = 0;
      cfg_write(0, 1 << 12, 0, 256, 1'b1);
      cfg_write(2, 1 << 13, 5, 200, 1'b1);
      start_pulse(10, 3);
      while (cyc < last_t0 + 6 && n < 100) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b0;
      clear_model_cfg();
      @(negedge clk);
      total += 4;
      if (busy !== 1'b0)           begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
      if (done !== 1'b0)           begin bad++; $display("FAIL midrst_done: got %b, required 0", done); end
      if (valid_wave_out !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b, required 0", valid_wave_out); end
      if (wave_out !== '0)         begin bad++; $display("FAIL midrst_wave: got %0d, required 0", $signed(wave_out)); end
      rst = 1'b1;
      repeat (12) @(negedge clk);
      total += 2;
      if (stray_done !== sd) begin bad++; $display("FAIL midrst_no_done: got %0d, required %0d", stray_done, sd); end
      if (sb_q.size() !== 0) begin bad++; $display("FAIL midrst_samples: got %0d pending, required 0", sb_q.size()); end
      start_pulse(4, 4);
      wait_idle("post_reset_zero");
      cfg_write(0, 1 << 12, 0, 256, 1'b1);
      start_pulse(8, 8);
      wait_idle("post_reset_lut");
   endtask

   initial begin
      #1500us;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; cfg_wr_en = 1'b0; cfg_ch_sel = '0; cfg_ftw = '0; cfg_phase_off = '0;
      cfg_amp = '0; cfg_ch_en = 1'b0; sin_lut_wr_en = 1'b0; sin_lut_wr_addr = '0;
      sin_lut_wr_data = '0; pulse_start = 1'b0; pulse_dur = '0;
      clear_model_cfg();
      @(negedge clk);
      test_reset();
      load_sine();
      test_single_tone();
      test_multi_tone();
      test_offset_clip();
      test_zero_len();
      test_back_to_back();
      test_long();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
